// File: rtl/fifo_request_arbiter_pkg.sv
// Shared definitions for the FIFO request arbiter.
//   arb_state_e          : arbiter FSM states (IDLE, ISSUE, ACK)
//   DEFAULT_ENTRY_WIDTH  : default entry width, matches fifo_queue
//   slice_lo()           : low bit of requester idx's slot in a packed request bus
package fifo_request_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } arb_state_e;

  localparam int unsigned DEFAULT_ENTRY_WIDTH = 32;

  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/round_robin_picker.sv
// Purely combinational round-robin selector.
//   valid     : per-requester valid vector
//   rr_ptr    : requester with highest priority this round
//   found     : at least one requester is valid
//   winner_id : first valid requester scanning circularly upward from rr_ptr
module round_robin_picker #(
  parameter int unsigned NUM_REQUESTERS     = 4,
  parameter int unsigned REQUESTER_ID_WIDTH = 2
) (
  input  logic [NUM_REQUESTERS-1:0]     valid,
  input  logic [REQUESTER_ID_WIDTH-1:0] rr_ptr,
  output logic                          found,
  output logic [REQUESTER_ID_WIDTH-1:0] winner_id
);

  always_comb begin
    int unsigned cand;
    found     = 1'b0;
    winner_id = '0;
    cand      = 0;
    for (int unsigned off = 0; off < NUM_REQUESTERS; off++) begin
      // Wrap by subtraction so non-power-of-two requester counts work.
      cand = 32'(rr_ptr) + off;
      if (cand >= NUM_REQUESTERS) begin
        cand = cand - NUM_REQUESTERS;
      end
      if (!found && valid[cand[REQUESTER_ID_WIDTH-1:0]]) begin
        found     = 1'b1;
        winner_id = cand[REQUESTER_ID_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_request_arbiter.sv
// Round-robin arbiter sharing one fifo_queue write port among several producers.
// A winner's entry is captured once at grant and held on the FIFO side until the
// FIFO acks; the winner then receives a single-cycle one-hot ack.
//   clk_in, reset_n_in      : clock, asynchronous active-low reset
//   request_packed_in       : requester i's entry at [i*W +: W]
//   request_valid_in        : per-requester valid, held until ack
//   issue_ack_out           : one-hot single-cycle ack to the granted requester
//   fifo_request_out        : entry presented to the FIFO
//   fifo_request_valid_out  : valid to the FIFO
//   fifo_issue_ack_in       : FIFO accepted the entry
//   fifo_is_full_in         : FIFO full, blocks new grants
//   grant_id_out            : current or last granted requester
//   busy_out                : arbiter not idle
module fifo_request_arbiter
  import fifo_request_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS             = 4,
  parameter int unsigned REQUESTER_ID_WIDTH         = 2,
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = DEFAULT_ENTRY_WIDTH
) (
  input  logic                                                 clk_in,
  input  logic                                                 reset_n_in,
  input  logic [NUM_REQUESTERS*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_packed_in,
  input  logic [NUM_REQUESTERS-1:0]                            request_valid_in,
  output logic [NUM_REQUESTERS-1:0]                            issue_ack_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]                fifo_request_out,
  output logic                                                 fifo_request_valid_out,
  input  logic                                                 fifo_issue_ack_in,
  input  logic                                                 fifo_is_full_in,
  output logic [REQUESTER_ID_WIDTH-1:0]                        grant_id_out,
  output logic                                                 busy_out
);

  localparam int unsigned W = SINGLE_ENTRY_WIDTH_IN_BITS;

  arb_state_e                    state, state_next;
  logic [REQUESTER_ID_WIDTH-1:0] rr_ptr, rr_ptr_next;
  logic                          pick_found;
  logic [REQUESTER_ID_WIDTH-1:0] pick_id;
  logic [W-1:0]                  pick_data;
  logic [REQUESTER_ID_WIDTH-1:0] grant_next;
  logic [W-1:0]                  entry_next;
  logic                          valid_next;
  logic [NUM_REQUESTERS-1:0]     ack_next;
  logic                          busy_next;

  round_robin_picker #(
    .NUM_REQUESTERS    (NUM_REQUESTERS),
    .REQUESTER_ID_WIDTH(REQUESTER_ID_WIDTH)
  ) u_picker (
    .valid    (request_valid_in),
    .rr_ptr   (rr_ptr),
    .found    (pick_found),
    .winner_id(pick_id)
  );

  always_comb begin
    pick_data = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (32'(pick_id) == i) begin
        pick_data = request_packed_in[slice_lo(i, W) +: W];
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state plus next values of every registered output, so no input
  // reaches an output without passing through a flop.
  always_comb begin
    state_next  = state;
    rr_ptr_next = rr_ptr;
    grant_next  = grant_id_out;
    entry_next  = fifo_request_out;
    valid_next  = fifo_request_valid_out;
    ack_next    = '0;
    case (state)
      IDLE: begin
        if (pick_found && !fifo_is_full_in) begin
          grant_next = pick_id;
          entry_next = pick_data;
          valid_next = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (fifo_issue_ack_in) begin
          valid_next             = 1'b0;
          ack_next[grant_id_out] = 1'b1;
          rr_ptr_next = (grant_id_out == REQUESTER_ID_WIDTH'(NUM_REQUESTERS - 1))
                        ? '0 : grant_id_out + REQUESTER_ID_WIDTH'(1);
          state_next  = ACK;
        end
      end
      ACK: begin
        // Requesters update on the edge they see their ack, so skip sampling here.
        state_next = IDLE;
      end
      default: begin
        valid_next = 1'b0;
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      rr_ptr                 <= '0;
      grant_id_out           <= '0;
      fifo_request_out       <= '0;
      fifo_request_valid_out <= 1'b0;
      issue_ack_out          <= '0;
      busy_out               <= 1'b0;
    end else begin
      rr_ptr                 <= rr_ptr_next;
      grant_id_out           <= grant_next;
      fifo_request_out       <= entry_next;
      fifo_request_valid_out <= valid_next;
      issue_ack_out          <= ack_next;
      busy_out               <= busy_next;
    end
  end

endmodule

// File: tb/tb_fifo_request_arbiter.sv
// Self-checking bench for fifo_request_arbiter: a transaction-level model
// predicts every registered output each cycle, and directed scenarios pin
// literal expectations (single request, wrap-around, fairness, full
// back-pressure, slow ack with data change, reset mid-issue).
module tb_fifo_request_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int W   = 32;

  logic             clk_in = 1'b0;
  logic             reset_n_in;
  logic [N*W-1:0]   request_packed_in;
  logic [N-1:0]     request_valid_in;
  logic [N-1:0]     issue_ack_out;
  logic [W-1:0]     fifo_request_out;
  logic             fifo_request_valid_out;
  logic             fifo_issue_ack_in = 1'b0;
  logic             fifo_is_full_in;
  logic [IDW-1:0]   grant_id_out;
  logic             busy_out;

  int checks   = 0;
  int failures = 0;

  fifo_request_arbiter #(
    .NUM_REQUESTERS            (N),
    .REQUESTER_ID_WIDTH        (IDW),
    .SINGLE_ENTRY_WIDTH_IN_BITS(W)
  ) dut (
    .clk_in                (clk_in),
    .reset_n_in            (reset_n_in),
    .request_packed_in     (request_packed_in),
    .request_valid_in      (request_valid_in),
    .issue_ack_out         (issue_ack_out),
    .fifo_request_out      (fifo_request_out),
    .fifo_request_valid_out(fifo_request_valid_out),
    .fifo_issue_ack_in     (fifo_issue_ack_in),
    .fifo_is_full_in       (fifo_is_full_in),
    .grant_id_out          (grant_id_out),
    .busy_out              (busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- FIFO responder: acks after ack_delay waiting cycles ----
  int ack_delay = 0;
  int wait_cnt  = 0;
  always @(negedge clk_in) begin
    if (fifo_issue_ack_in) begin
      fifo_issue_ack_in = 1'b0;
    end else if (fifo_request_valid_out) begin
      if (wait_cnt >= ack_delay) begin
        fifo_issue_ack_in = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // ---------------- Model + per-cycle comparison --------------------------
  // m_phase: 0 waiting for a winner, 1 entry offered to FIFO, 2 ack to requester
  int           m_phase = 0;
  int           m_ptr   = 0;
  int           m_grant = 0;
  logic [W-1:0] m_data  = '0;
  logic         m_valid = 1'b0;
  logic [N-1:0] m_ack   = '0;

  int pushes = 0;
  int cyc    = 0;
  int ack_count [N] = '{default: 0};
  int grant_log [$];
  int grant_cyc [$];

  always @(posedge clk_in) begin
    logic [N-1:0]   v;
    logic [N*W-1:0] pk;
    logic           full, fack, found;
    int             pick, id;
    static logic    was_valid = 1'b0;
    cyc++;
    v     = request_valid_in;
    pk    = request_packed_in;
    full  = fifo_is_full_in;
    fack  = fifo_issue_ack_in;
    found = 1'b0;
    pick  = 0;
    if (fifo_request_valid_out && fack) pushes++;
    if (!reset_n_in) begin
      m_phase = 0; m_ptr = 0; m_grant = 0; m_data = '0; m_valid = 1'b0; m_ack = '0;
    end else begin
      case (m_phase)
        0: begin
          m_ack = '0;
          for (int k = 0; k < N; k++) begin
            id = (m_ptr + k) % N;
            if (!found && v[id]) begin
              found = 1'b1;
              pick  = id;
            end
          end
          if (found && !full) begin
            m_grant = pick;
            m_data  = pk[pick*W +: W];
            m_valid = 1'b1;
            m_phase = 1;
          end
        end
        1: begin
          if (fack) begin
            m_valid = 1'b0;
            m_ack   = '0;
            m_ack[m_grant] = 1'b1;
            m_ptr   = (m_grant + 1) % N;
            m_phase = 2;
          end
        end
        default: begin
          m_ack   = '0;
          m_phase = 0;
        end
      endcase
    end
    #1;
    check("cyc_fifo_valid", fifo_request_valid_out, m_valid);
    check("cyc_fifo_data", fifo_request_out, m_data);
    check("cyc_issue_ack", issue_ack_out, m_ack);
    check("cyc_grant_id", grant_id_out, m_grant);
    check("cyc_busy", busy_out, m_phase != 0);
    check("cyc_ack_onehot", $countones(issue_ack_out) <= 1, 1);
    if (fifo_request_valid_out && !was_valid) begin
      grant_log.push_back(int'(grant_id_out));
      grant_cyc.push_back(cyc);
    end
    was_valid = fifo_request_valid_out;
    for (int i = 0; i < N; i++) if (issue_ack_out[i]) ack_count[i]++;
  end

  // ---------------- Stimulus helpers --------------------------------------
  logic drop_on_ack = 1'b1;

  task automatic cycle();
    @(negedge clk_in);
    if (drop_on_ack) request_valid_in = request_valid_in & ~issue_ack_out;
  endtask

  task automatic set_entry(input int i, input logic [W-1:0] d);
    request_packed_in[i*W +: W] = d;
  endtask

  task automatic do_reset();
    reset_n_in = 1'b0;
    cycle();
    cycle();
    reset_n_in = 1'b1;
    cycle();
  endtask

  initial begin
    int p0, mark, hi, mn, mx, tot;
    int snap [N];
    reset_n_in        = 1'b0;
    request_packed_in = '0;
    request_valid_in  = '0;
    fifo_is_full_in   = 1'b0;

    // Reset values
    cycle();
    cycle();
    check("rst_fifo_valid", fifo_request_valid_out, 0);
    check("rst_fifo_data", fifo_request_out, 0);
    check("rst_issue_ack", issue_ack_out, 0);
    check("rst_grant", grant_id_out, 0);
    check("rst_busy", busy_out, 0);
    reset_n_in = 1'b1;
    cycle();

    // Single request from requester 2
    p0 = pushes;
    set_entry(2, 32'hDEADBEEF);
    request_valid_in = 4'b0100;
    cycle();
    check("single_valid_rise", fifo_request_valid_out, 1);
    check("single_data", fifo_request_out, 32'hDEADBEEF);
    check("single_grant", grant_id_out, 2);
    check("single_no_early_ack", issue_ack_out, 0);
    cycle();
    check("single_ack", issue_ack_out, 4'b0100);
    check("single_valid_fall", fifo_request_valid_out, 0);
    cycle();
    check("single_ack_one_cycle", issue_ack_out, 0);
    check("single_idle", busy_out, 0);
    repeat (3) cycle();
    check("single_push_count", pushes - p0, 1);

    // Wrap-around: pointer now at 3, requesters 0 and 1 valid
    mark = grant_log.size();
    set_entry(0, 32'h0000_0100);
    set_entry(1, 32'h0000_0111);
    request_valid_in = 4'b0011;
    repeat (10) cycle();
    check("wrap_grant_count", grant_log.size() - mark, 2);
    if (grant_log.size() - mark >= 2) begin
      check("wrap_first", grant_log[mark], 0);
      check("wrap_second", grant_log[mark+1], 1);
    end

    // Fairness: all four continuously valid, FIFO acks immediately
    do_reset();
    drop_on_ack = 1'b0;
    mark = grant_log.size();
    for (int i = 0; i < N; i++) begin
      snap[i] = ack_count[i];
      set_entry(i, 32'hF0 + i);
    end
    request_valid_in = 4'b1111;
    repeat (18) cycle();
    request_valid_in = '0;
    repeat (5) cycle();
    drop_on_ack = 1'b1;
    check("fair_grant_count", grant_log.size() - mark, 6);
    if (grant_log.size() - mark >= 6) begin
      check("fair_order0", grant_log[mark+0], 0);
      check("fair_order1", grant_log[mark+1], 1);
      check("fair_order2", grant_log[mark+2], 2);
      check("fair_order3", grant_log[mark+3], 3);
      check("fair_order4", grant_log[mark+4], 0);
      check("fair_order5", grant_log[mark+5], 1);
      for (int g = 1; g < 6; g++)
        check("fair_spacing", grant_cyc[mark+g] - grant_cyc[mark+g-1], 3);
    end
    mn = 1000; mx = 0; tot = 0;
    for (int i = 0; i < N; i++) begin
      if (ack_count[i] - snap[i] < mn) mn = ack_count[i] - snap[i];
      if (ack_count[i] - snap[i] > mx) mx = ack_count[i] - snap[i];
      tot += ack_count[i] - snap[i];
    end
    check("fair_ack_total", tot, 6);
    check("fair_ack_spread", mx - mn <= 1, 1);

    // Full back-pressure: requester 1 waits until full drops at cycle 20
    do_reset();
    fifo_is_full_in = 1'b1;
    set_entry(1, 32'h1111_0001);
    request_valid_in = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      cycle();
      check("full_busy_low", busy_out, 0);
      check("full_no_valid", fifo_request_valid_out, 0);
    end
    fifo_is_full_in = 1'b0;
    cycle();
    check("full_release_grant", fifo_request_valid_out, 1);
    check("full_release_id", grant_id_out, 1);
    repeat (4) cycle();

    // Slow ack: 7 waiting cycles, requester changes data mid-issue
    ack_delay = 7;
    p0 = pushes;
    set_entry(3, 32'h1234_5678);
    request_valid_in = 4'b1000;
    cycle();
    check("slow_grant", fifo_request_valid_out, 1);
    check("slow_grant_id", grant_id_out, 3);
    hi = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) set_entry(3, 32'hCAFE_F00D);
      if (fifo_request_valid_out) begin
        hi++;
        check("slow_hold_data", fifo_request_out, 32'h1234_5678);
      end
      cycle();
    end
    check("slow_valid_cycles", hi, 8);
    check("slow_single_push", pushes - p0, 1);
    ack_delay = 0;

    // Reset mid-issue: move pointer to 2, start a slow issue, then reset
    set_entry(1, 32'h0BAD_0001);
    request_valid_in = 4'b0010;
    repeat (5) cycle();
    ack_delay = 5;
    set_entry(2, 32'h2222_2222);
    request_valid_in = 4'b0100;
    cycle();
    check("rmid_grant", grant_id_out, 2);
    cycle();
    cycle();
    check("rmid_in_issue", fifo_request_valid_out, 1);
    reset_n_in = 1'b0;
    #1;
    check("rmid_valid_zero", fifo_request_valid_out, 0);
    check("rmid_data_zero", fifo_request_out, 0);
    check("rmid_ack_zero", issue_ack_out, 0);
    check("rmid_grant_zero", grant_id_out, 0);
    check("rmid_busy_zero", busy_out, 0);
    set_entry(0, 32'h0000_AAAA);
    set_entry(3, 32'h0000_3333);
    request_valid_in = 4'b1001;
    cycle();
    cycle();
    reset_n_in = 1'b1;
    ack_delay  = 0;
    cycle();
    check("rmid_restart_valid", fifo_request_valid_out, 1);
    check("rmid_restart_id", grant_id_out, 0);
    check("rmid_restart_data", fifo_request_out, 32'h0000_AAAA);
    repeat (10) cycle();
    check("rmid_drain", request_valid_in, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
